// File: rtl/dmem_arbiter_if.sv
// Request/grant and data-memory port bundle shared by dmem_arbiter and its requesters.
// Handshake: a requester holds *_req and its fields stable until it sees *_gnt high in the
// same cycle; each gnt consumes one request, and a req still high next cycle is a new request.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              p_req;
  logic [3:0]        p_we;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_rvalid;
  logic [DATA_W-1:0] p_rdata;

  logic              s_req;
  logic [3:0]        s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_gnt;
  logic              s_rvalid;
  logic [DATA_W-1:0] s_rdata;

  logic              v_req;
  logic              v_is_store;
  logic [ADDR_W-1:0] v_addr0, v_addr1, v_addr2, v_addr3;
  logic [DATA_W-1:0] v_wdata0, v_wdata1, v_wdata2, v_wdata3;
  logic              v_gnt;
  logic              v_done;
  logic [DATA_W-1:0] v_rdata0, v_rdata1, v_rdata2, v_rdata3;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_gnt, p_rvalid, p_rdata,
    input  s_req, s_we, s_addr, s_wdata,
    output s_gnt, s_rvalid, s_rdata,
    input  v_req, v_is_store, v_addr0, v_addr1, v_addr2, v_addr3,
    input  v_wdata0, v_wdata1, v_wdata2, v_wdata3,
    output v_gnt, v_done, v_rdata0, v_rdata1, v_rdata2, v_rdata3,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_gnt, p_rvalid, p_rdata,
    output s_req, s_we, s_addr, s_wdata,
    input  s_gnt, s_rvalid, s_rdata,
    output v_req, v_is_store, v_addr0, v_addr1, v_addr2, v_addr3,
    output v_wdata0, v_wdata1, v_wdata2, v_wdata3,
    input  v_gnt, v_done, v_rdata0, v_rdata1, v_rdata2, v_rdata3,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: P > S > V single-word grants, 4-beat vector bursts.
// Optional vector aging is enabled by defining DMEM_ARB_AGING_EN.
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  localparam int SW        = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic [1:0]    o_dbg_state,
  output logic [SW-1:0] o_dbg_starve
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_VBURST = 2'd1;
  localparam logic [1:0] ST_VDRAIN = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             r_beat;
  logic                   r_is_store;
  logic [3:0][ADDR_W-1:0] r_vaddr;
  logic [3:0][DATA_W-1:0] r_vwdata;
  logic [2:0][DATA_W-1:0] r_vbuf;
  logic [3:0][DATA_W-1:0] r_vrdata;
  logic                   r_p_rvalid;
  logic                   r_s_rvalid;
  logic                   r_v_done;

  logic w_idle, w_force_v, w_p_win, w_s_win, w_v_win;

  assign w_idle = (r_state == ST_IDLE);

`ifdef DMEM_ARB_AGING_EN
  logic [SW-1:0] r_starve;
  assign w_force_v = bus.v_req && (r_starve == SW'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_v_win) begin
      r_starve <= '0;
    end else if (w_idle && bus.v_req && (r_starve != SW'(STARVE_MAX))) begin
      r_starve <= r_starve + 1'b1;
    end
  end
  assign o_dbg_starve = r_starve;
`else
  assign w_force_v    = 1'b0;
  assign o_dbg_starve = '0;
`endif

  assign w_p_win = w_idle && bus.p_req && !w_force_v;
  assign w_s_win = w_idle && bus.s_req && !bus.p_req && !w_force_v;
  assign w_v_win = w_idle && bus.v_req && (w_force_v || (!bus.p_req && !bus.s_req));

  // Beat 0 comes straight from the requester; beats 1..3 from the captured lanes.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_p_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.p_we;
      bus.mem_addr  = bus.p_addr;
      bus.mem_wdata = bus.p_wdata;
    end else if (w_s_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.s_we;
      bus.mem_addr  = bus.s_addr;
      bus.mem_wdata = bus.s_wdata;
    end else if (w_v_win) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.v_is_store ? 4'hF : 4'h0;
      bus.mem_addr  = bus.v_addr0;
      bus.mem_wdata = bus.v_wdata0;
    end else if (r_state == ST_VBURST) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = r_is_store ? 4'hF : 4'h0;
      bus.mem_addr  = r_vaddr[r_beat];
      bus.mem_wdata = r_vwdata[r_beat];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_beat     <= 2'd0;
      r_is_store <= 1'b0;
      r_vaddr    <= '0;
      r_vwdata   <= '0;
      r_vbuf     <= '0;
      r_vrdata   <= '0;
      r_p_rvalid <= 1'b0;
      r_s_rvalid <= 1'b0;
      r_v_done   <= 1'b0;
    end else begin
      r_p_rvalid <= w_p_win && (bus.p_we == 4'h0);
      r_s_rvalid <= w_s_win && (bus.s_we == 4'h0);
      r_v_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_v_win) begin
            r_vaddr    <= {bus.v_addr3, bus.v_addr2, bus.v_addr1, bus.v_addr0};
            r_vwdata   <= {bus.v_wdata3, bus.v_wdata2, bus.v_wdata1, bus.v_wdata0};
            r_is_store <= bus.v_is_store;
            r_beat     <= 2'd1;
            r_state    <= ST_VBURST;
          end
        end
        ST_VBURST: begin
          // mem_rdata now holds the previous beat's word.
          if (!r_is_store) r_vbuf[r_beat - 2'd1] <= bus.mem_rdata;
          r_beat <= r_beat + 2'd1;
          if (r_beat == 2'd3) r_state <= ST_VDRAIN;
        end
        ST_VDRAIN: begin
          if (!r_is_store) r_vrdata <= {bus.mem_rdata, r_vbuf[2], r_vbuf[1], r_vbuf[0]};
          r_v_done <= 1'b1;
          r_beat   <= 2'd0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.p_gnt    = w_p_win;
  assign bus.s_gnt    = w_s_win;
  assign bus.v_gnt    = w_v_win;
  assign bus.p_rvalid = r_p_rvalid;
  assign bus.s_rvalid = r_s_rvalid;
  assign bus.p_rdata  = r_p_rvalid ? bus.mem_rdata : '0;
  assign bus.s_rdata  = r_s_rvalid ? bus.mem_rdata : '0;
  assign bus.v_done   = r_v_done;
  assign bus.v_rdata0 = r_vrdata[0];
  assign bus.v_rdata1 = r_vrdata[1];
  assign bus.v_rdata2 = r_vrdata[2];
  assign bus.v_rdata3 = r_vrdata[3];
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 1-cycle-latency BRAM model.
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_starve;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  logic [3:0][DW-1:0] last_vr;
  int            checks;
  int            errors;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(8)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .o_dbg_state  (dbg_state),
    .o_dbg_starve (dbg_starve)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // memory model: byte-enable writes, registered read
  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state act=%0d exp=0", dbg_state); end
    checks++; if ({bus.p_gnt, bus.s_gnt, bus.v_gnt, bus.p_rvalid, bus.s_rvalid, bus.v_done, bus.mem_en} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl act=%b exp=0", {bus.p_gnt, bus.s_gnt, bus.v_gnt, bus.p_rvalid, bus.s_rvalid, bus.v_done, bus.mem_en}); end
    checks++; if (bus.mem_we !== 4'h0) begin errors++; $display("FAIL reset_mem_we act=%h exp=0", bus.mem_we); end
    checks++; if ({bus.v_rdata0, bus.v_rdata1, bus.v_rdata2, bus.v_rdata3} !== 128'd0) begin errors++; $display("FAIL reset_vrdata act=%h exp=0", {bus.v_rdata0, bus.v_rdata1, bus.v_rdata2, bus.v_rdata3}); end
    checks++; if (dbg_starve !== 4'd0) begin errors++; $display("FAIL reset_starve act=%0d exp=0", dbg_starve); end
    rst = 1'b0;
  endtask

  task automatic test_scalar_read();
    logic [DW-1:0] e;
    @(negedge clk);
    bus.s_req = 1'b1; bus.s_we = 4'h0; bus.s_addr = 12'h010;
    #1;
    checks++; if (bus.s_gnt !== 1'b1) begin errors++; $display("FAIL sread_gnt act=%b exp=1", bus.s_gnt); end
    checks++; if (bus.mem_addr !== 12'h010 || bus.mem_en !== 1'b1) begin errors++; $display("FAIL sread_mem act=%h/%b exp=010/1", bus.mem_addr, bus.mem_en); end
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    bus.s_req = 1'b0;
    #1;
    checks++; if (bus.s_rvalid !== 1'b1) begin errors++; $display("FAIL sread_rvalid act=%b exp=1", bus.s_rvalid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.s_rdata !== e) begin errors++; $display("FAIL sread_rdata act=%h exp=%h", bus.s_rdata, e); end
    checks++; if (bus.p_rvalid !== 1'b0) begin errors++; $display("FAIL sread_prvalid act=%b exp=0", bus.p_rvalid); end
  endtask

  task automatic test_scalar_write();
    @(negedge clk);
    bus.s_req = 1'b1; bus.s_we = 4'hF; bus.s_addr = 12'h030; bus.s_wdata = 32'hCAFEF00D;
    #1;
    checks++; if (bus.s_gnt !== 1'b1 || bus.mem_we !== 4'hF || bus.mem_wdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL swrite_issue act=%b/%h/%h exp=1/f/cafef00d", bus.s_gnt, bus.mem_we, bus.mem_wdata); end
    @(negedge clk);
    bus.s_req = 1'b0; bus.s_we = 4'h0;
    #1;
    checks++; if (bus.s_rvalid !== 1'b0) begin errors++; $display("FAIL swrite_rvalid act=%b exp=0", bus.s_rvalid); end
  endtask

  task automatic test_priority();
    logic [DW-1:0] e;
    @(negedge clk);
    bus.p_req = 1'b1; bus.p_we = 4'h0; bus.p_addr = 12'h010;
    bus.s_req = 1'b1; bus.s_we = 4'h0; bus.s_addr = 12'h030;
    #1;
    checks++; if (bus.p_gnt !== 1'b1 || bus.s_gnt !== 1'b0) begin errors++; $display("FAIL prio_t0 act=p%b s%b exp=p1 s0", bus.p_gnt, bus.s_gnt); end
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    bus.p_req = 1'b0;
    #1;
    checks++; if (bus.s_gnt !== 1'b1 || bus.mem_addr !== 12'h030) begin errors++; $display("FAIL prio_t1 act=s%b %h exp=s1 030", bus.s_gnt, bus.mem_addr); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.p_rvalid !== 1'b1 || bus.p_rdata !== e) begin errors++; $display("FAIL prio_prdata act=%b/%h exp=1/%h", bus.p_rvalid, bus.p_rdata, e); end
    exp_q.push_back(32'hCAFEF00D);
    @(negedge clk);
    bus.s_req = 1'b0;
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== e) begin errors++; $display("FAIL prio_srdata act=%b/%h exp=1/%h", bus.s_rvalid, bus.s_rdata, e); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [3];
    logic [DW-1:0] d [3];
    logic [DW-1:0] e;
    a[0] = 12'h030; a[1] = 12'h010; a[2] = 12'h030;
    d[0] = 32'hCAFEF00D; d[1] = 32'hDEADBEEF; d[2] = 32'hCAFEF00D;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3) begin bus.s_req = 1'b1; bus.s_we = 4'h0; bus.s_addr = a[i]; end
      else bus.s_req = 1'b0;
      #1;
      if (i > 0) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== e) begin errors++; $display("FAIL b2b_rdata%0d act=%b/%h exp=1/%h", i, bus.s_rvalid, bus.s_rdata, e); end
      end
      if (i < 3) begin
        checks++; if (bus.s_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d act=%b exp=1", i, bus.s_gnt); end
        exp_q.push_back(d[i]);
      end
    end
  endtask

  task automatic set_vreq(input logic st, input logic [AW-1:0] base, input logic [3:0][DW-1:0] d);
    bus.v_req = 1'b1; bus.v_is_store = st;
    bus.v_addr0 = base; bus.v_addr1 = base + 12'd1; bus.v_addr2 = base + 12'd2; bus.v_addr3 = base + 12'd3;
    bus.v_wdata0 = d[0]; bus.v_wdata1 = d[1]; bus.v_wdata2 = d[2]; bus.v_wdata3 = d[3];
  endtask

  task automatic scramble_v();
    bus.v_addr1 = 12'($urandom_range(0, 4095)); bus.v_addr2 = 12'($urandom_range(0, 4095));
    bus.v_addr3 = 12'($urandom_range(0, 4095)); bus.v_wdata1 = $urandom; bus.v_wdata2 = $urandom;
    bus.v_wdata3 = $urandom; bus.v_is_store = ~bus.v_is_store;
  endtask

  task automatic run_vburst(input logic st, input logic [AW-1:0] base, input logic [3:0][DW-1:0] d);
    logic [DW-1:0] e;
    logic [3:0][DW-1:0] got;
    @(negedge clk);
    set_vreq(st, base, d);
    #1;
    checks++; if (bus.v_gnt !== 1'b1 || bus.mem_addr !== base || bus.mem_we !== (st ? 4'hF : 4'h0)) begin
      errors++; $display("FAIL vb_beat0 act=%b/%h/%h exp=1/%h/%h", bus.v_gnt, bus.mem_addr, bus.mem_we, base, st ? 4'hF : 4'h0); end
    if (!st) for (int k = 0; k < 4; k++) exp_q.push_back(d[k]);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.v_req = 1'b0; scramble_v(); end
      #1;
      checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== base + 12'(k) || bus.mem_we !== (st ? 4'hF : 4'h0) ||
                    (st && bus.mem_wdata !== d[k])) begin
        errors++; $display("FAIL vb_beat%0d act=%b/%h/%h/%h exp=1/%h/%h/%h", k, bus.mem_en, bus.mem_addr, bus.mem_we, bus.mem_wdata,
                           base + 12'(k), st ? 4'hF : 4'h0, d[k]); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.mem_en !== 1'b0 || dbg_state !== 2'd2 || bus.v_done !== 1'b0) begin
      errors++; $display("FAIL vb_drain act=%b/%0d/%b exp=0/2/0", bus.mem_en, dbg_state, bus.v_done); end
    @(negedge clk);
    #1;
    checks++; if (bus.v_done !== 1'b1) begin errors++; $display("FAIL vb_done act=%b exp=1", bus.v_done); end
    got = {bus.v_rdata3, bus.v_rdata2, bus.v_rdata1, bus.v_rdata0};
    if (!st) last_vr = d;
    for (int k = 0; k < 4; k++) begin
      if (!st) e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      else e = last_vr[k];
      checks++; if (got[k] !== e) begin errors++; $display("FAIL vb_rdata%0d act=%h exp=%h", k, got[k], e); end
    end
    @(negedge clk);
    #1;
    checks++; if (bus.v_done !== 1'b0) begin errors++; $display("FAIL vb_done_pulse act=%b exp=0", bus.v_done); end
  endtask

  task automatic test_vector_store_load();
    logic [3:0][DW-1:0] d;
    d = {32'h44, 32'h33, 32'h22, 32'h11};
    run_vburst(1'b1, 12'h020, d);
    run_vburst(1'b0, 12'h020, d);
  endtask

  task automatic test_s_during_burst();
    logic [DW-1:0] e;
    @(negedge clk);
    set_vreq(1'b0, 12'h020, last_vr);
    #1;
    checks++; if (bus.v_gnt !== 1'b1) begin errors++; $display("FAIL sdb_vgnt act=%b exp=1", bus.v_gnt); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin bus.v_req = 1'b0; bus.s_req = 1'b1; bus.s_we = 4'h0; bus.s_addr = 12'h010; end
      #1;
      checks++; if (bus.s_gnt !== (c == 5)) begin errors++; $display("FAIL sdb_sgnt_T%0d act=%b exp=%b", c, bus.s_gnt, c == 5); end
    end
    exp_q.push_back(32'hDEADBEEF);
    checks++; if (bus.v_done !== 1'b1 || bus.v_rdata2 !== 32'h33) begin errors++; $display("FAIL sdb_vdone act=%b/%h exp=1/33", bus.v_done, bus.v_rdata2); end
    @(negedge clk);
    bus.s_req = 1'b0;
    #1;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    checks++; if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== e) begin errors++; $display("FAIL sdb_srdata act=%b/%h exp=1/%h", bus.s_rvalid, bus.s_rdata, e); end
  endtask

  task automatic test_aging();
    int gnt_cyc;
    int p_gnts;
    gnt_cyc = 0;
    p_gnts  = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.p_req = 1'b1; bus.p_we = 4'hF; bus.p_addr = 12'h040; bus.p_wdata = 32'h55;
        set_vreq(1'b0, 12'h020, last_vr);
      end
      #1;
      if (bus.p_gnt) p_gnts++;
      if (bus.v_gnt) begin
        gnt_cyc = c;
        checks++; if (bus.p_gnt !== 1'b0) begin errors++; $display("FAIL aging_pgnt_at_vgnt act=%b exp=0", bus.p_gnt); end
        break;
      end
    end
`ifdef DMEM_ARB_AGING_EN
    checks++; if (gnt_cyc != 9) begin errors++; $display("FAIL aging_vgnt_cycle act=%0d exp=9", gnt_cyc); end
    checks++; if (p_gnts != 8) begin errors++; $display("FAIL aging_pgnts act=%0d exp=8", p_gnts); end
`else
    checks++; if (gnt_cyc != 0) begin errors++; $display("FAIL noaging_vgnt_cycle act=%0d exp=0", gnt_cyc); end
    checks++; if (p_gnts != 20) begin errors++; $display("FAIL noaging_pgnts act=%0d exp=20", p_gnts); end
`endif
    @(negedge clk);
    bus.p_req = 1'b0; bus.p_we = 4'h0;
    #1;
`ifndef DMEM_ARB_AGING_EN
    checks++; if (bus.v_gnt !== 1'b1) begin errors++; $display("FAIL noaging_vgnt_after_p act=%b exp=1", bus.v_gnt); end
`endif
    @(negedge clk);
    bus.v_req = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (dbg_state !== 2'd0 || dbg_starve !== 4'd0) begin errors++; $display("FAIL aging_end act=%0d/%0d exp=0/0", dbg_state, dbg_starve); end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    set_vreq(1'b0, 12'h020, last_vr);
    #1;
    checks++; if (bus.v_gnt !== 1'b1) begin errors++; $display("FAIL rmb_vgnt act=%b exp=1", bus.v_gnt); end
    @(negedge clk);
    bus.v_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (dbg_state !== 2'd0 || bus.mem_we !== 4'h0 || bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL rmb_idle act=%0d/%h/%b exp=0/0/0", dbg_state, bus.mem_we, bus.mem_en); end
    checks++; if ({bus.v_rdata0, bus.v_rdata1, bus.v_rdata2, bus.v_rdata3} !== 128'd0) begin
      errors++; $display("FAIL rmb_vrdata act=%h exp=0", {bus.v_rdata0, bus.v_rdata1, bus.v_rdata2, bus.v_rdata3}); end
    last_vr = '0;
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      if (c == 4) begin bus.s_req = 1'b1; bus.s_we = 4'h0; bus.s_addr = 12'h030; end
      else bus.s_req = 1'b0;
      #1;
      if (c == 4) begin
        checks++; if (bus.s_gnt !== 1'b1) begin errors++; $display("FAIL rmb_sgnt act=%b exp=1", bus.s_gnt); end
      end
      checks++; if (bus.v_done !== 1'b0) begin errors++; $display("FAIL rmb_vdone_T%0d act=%b exp=0", c, bus.v_done); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_vr = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h010] = 32'hDEADBEEF;
    bus.p_req = 1'b0; bus.p_we = 4'h0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.s_req = 1'b0; bus.s_we = 4'h0; bus.s_addr = '0; bus.s_wdata = '0;
    bus.v_req = 1'b0; bus.v_is_store = 1'b0;
    bus.v_addr0 = '0; bus.v_addr1 = '0; bus.v_addr2 = '0; bus.v_addr3 = '0;
    bus.v_wdata0 = '0; bus.v_wdata1 = '0; bus.v_wdata2 = '0; bus.v_wdata3 = '0;
    rst = 1'b1;
    test_reset();
    test_scalar_read();
    test_scalar_write();
    test_priority();
    test_back_to_back();
    test_vector_store_load();
    test_s_during_burst();
    test_aging();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover act=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
